// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the counter-width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1; one extra code keeps WIDTH=1 at one bit.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half adders and an OR gate.
// The serial controller drives exactly one instance of this cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic hs1;
    logic hc1;
    logic hc2;

    // First half adder: a + b
    assign hs1  = a ^ b;
    assign hc1  = a & b;

    // Second half adder folds in the carry
    assign sum  = hs1 ^ cin;
    assign hc2  = hs1 & cin;

    // Only one half adder can carry at a time
    assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one operand bit per clock through fa_cell.
// Accepts a job in IDLE, shifts for WIDTH cycles in RUN, presents it in DONE.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             in_run;
    logic             last;

    assign accept = (state == IDLE) && in_valid;
    assign in_run = (state == RUN);
    assign last   = in_run && (cnt == LAST);

    fa_cell u_fa (
        .a    (opa_sr[0]),
        .b    (opb_sr[0]),
        .cin  (carry),
        .sum  (bit_s),
        .cout (bit_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = bit_s;
        end else begin : g_wn
            assign sum_shift = {bit_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand load on accept, one serial step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_sr <= '0;
            opb_sr <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            opa_sr <= a;
            opb_sr <= b;
            carry  <= cin;
            cnt    <= '0;
        end else if (in_run) begin
            opa_sr <= opa_sr >> 1;
            opb_sr <= opb_sr >> 1;
            sum_sr <= sum_shift;
            carry  <= bit_c;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result register: updated only when a job completes, so it
    // keeps the previous answer through the next job's RUN phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (last) begin
            sum_q  <= sum_shift;
            cout_q <= bit_c;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH 8, 13 and 1.
// Expected sums are pushed on accept and popped when out_valid rises.
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv   [3];
    logic        ordy [3];
    logic        ci   [3];
    logic [63:0] aa   [3];
    logic [63:0] bb   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        bz   [3];
    logic        co   [3];

    logic [7:0]  s8;
    logic [12:0] s13;
    logic [0:0]  s1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wid [3] = '{8, 13, 1};

    logic [64:0] sbq [$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .a         (aa[0][7:0]),
        .b         (bb[0][7:0]),
        .cin       (ci[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .sum       (s8),
        .cout      (co[0]),
        .busy      (bz[0])
    );

    serial_add_ctrl #(.WIDTH(13)) u13 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .a         (aa[1][12:0]),
        .b         (bb[1][12:0]),
        .cin       (ci[1]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .sum       (s13),
        .cout      (co[1]),
        .busy      (bz[1])
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[2]),
        .in_ready  (ir[2]),
        .a         (aa[2][0:0]),
        .b         (bb[2][0:0]),
        .cin       (ci[2]),
        .out_valid (ov[2]),
        .out_ready (ordy[2]),
        .sum       (s1),
        .cout      (co[2]),
        .busy      (bz[2])
    );

    function automatic logic [63:0] rd_sum(int s);
        case (s)
            0:       return 64'(s8);
            1:       return 64'(s13);
            default: return 64'(s1);
        endcase
    endfunction

    function automatic logic [63:0] mask_of(int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a job and wait (bounded) for the accepting edge.
    task automatic send(int s, logic [63:0] a, logic [63:0] b, logic c);
        logic [63:0] m;
        logic [64:0] t;
        int          n;
        m = mask_of(wid[s]);
        t = {1'b0, a & m} + {1'b0, b & m} + 65'(c);
        aa[s] = a & m;
        bb[s] = b & m;
        ci[s] = c;
        iv[s] = 1'b1;
        n = 0;
        while (!ir[s] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir[s]) begin
            check("accept_timeout", 64'(ir[s]), 64'd1);
            iv[s] = 1'b0;
            return;
        end
        sbq.push_back({t[wid[s]], t[63:0] & m});
        @(posedge clk);
        @(negedge clk);
        iv[s] = 1'b0;
    endtask

    // Wait for the result, hold off for 'hold' cycles, then retire.
    task automatic recv(int s, string tag, int hold, bit chk_lat);
        logic [64:0] e;
        int          lat;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sbq.pop_front();
        lat = 1;
        while (!ov[s] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(ov[s]), 64'd1);
        if (!ov[s]) return;
        if (chk_lat) check({tag, "_lat"}, 64'(lat), 64'(wid[s] + 1));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_v"}, 64'(ov[s]), 64'd1);
            check({tag, "_hold_s"}, rd_sum(s), e[63:0]);
            check({tag, "_hold_c"}, 64'(co[s]), 64'(e[64]));
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, "_sum"}, rd_sum(s), e[63:0]);
        check({tag, "_cout"}, 64'(co[s]), 64'(e[64]));
        check({tag, "_busy"}, 64'(bz[s]), 64'd1);
        ordy[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[s] = 1'b0;
        check({tag, "_retired"}, 64'(ov[s]), 64'd0);
        check({tag, "_idle_rdy"}, 64'(ir[s]), 64'd1);
        check({tag, "_kept"}, rd_sum(s), e[63:0]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            ci[i]   = 1'b0;
            aa[i]   = '0;
            bb[i]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 64'(ir[i]), 64'd1);
            check("rst_valid", 64'(ov[i]), 64'd0);
            check("rst_busy", 64'(bz[i]), 64'd0);
            check("rst_sum", rd_sum(i), 64'd0);
            check("rst_cout", 64'(co[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH=8 cases, including the 9-edge latency
        send(0, 64'hFF, 64'h01, 1'b0);
        recv(0, "ff_01", 0, 1'b1);
        send(0, 64'h5A, 64'hA5, 1'b1);
        recv(0, "5a_a5", 0, 1'b1);
        send(0, 64'h00, 64'h00, 1'b1);
        recv(0, "zero_c", 0, 1'b1);

        // Backpressure: five held cycles, retire on the sixth
        send(0, 64'h7F, 64'h80, 1'b1);
        recv(0, "bp", 5, 1'b1);

        // Extra in_valid during RUN must be ignored
        send(0, 64'h12, 64'h34, 1'b0);
        iv[0] = 1'b1;
        aa[0] = 64'h33;
        bb[0] = 64'h33;
        check("midrun_rdy", 64'(ir[0]), 64'd0);
        check("midrun_busy", 64'(bz[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrun_rdy2", 64'(ir[0]), 64'd0);
        iv[0] = 1'b0;
        recv(0, "midrun", 0, 1'b0);

        // Async reset after three RUN edges discards the job
        send(0, 64'hC3, 64'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(ir[0]), 64'd1);
        check("arst_valid", 64'(ov[0]), 64'd0);
        check("arst_busy", 64'(bz[0]), 64'd0);
        check("arst_sum", rd_sum(0), 64'd0);
        check("arst_cout", 64'(co[0]), 64'd0);
        void'(sbq.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_rel_rdy", 64'(ir[0]), 64'd1);
        check("arst_rel_vld", 64'(ov[0]), 64'd0);

        // WIDTH=1: RUN is a single cycle
        send(2, 64'd1, 64'd1, 1'b1);
        recv(2, "w1", 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(2, 64'(i[2]), 64'(i[1]), i[0]);
            recv(2, "w1_all", i % 2, 1'b1);
        end

        // Random scoreboard runs at WIDTH 8 and 13
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1000; i++) begin
                send(k, {$urandom, $urandom}, {$urandom, $urandom},
                     1'($urandom_range(1)));
                recv(k, (k == 0) ? "rnd8" : "rnd13",
                     $urandom_range(2), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
